bcd_arbiter: RTL



---
 rtl/bcd_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/bcd_arbiter.sv
// ----------------------------------------------------------------------------
// bcd_arbiter
//   Round-robin arbiter/sequencer sharing one double_dabble binary-to-BCD
//   converter among NUM_REQ requesters. One conversion is in flight at a time;
//   the result (or a timeout abort) is returned to the winning requester with
//   a one-cycle resp_valid pulse.
//
// Ports
//   clk_i                system clock
//   rst_ni               asynchronous active-low reset
//   req_valid_i          per-requester request level, held until req_ack_o
//   req_data_i           requester i value in [i*DATA_IN_BITS +: DATA_IN_BITS]
//   req_ack_o            one-hot, one-cycle pulse when a request is latched
//   resp_valid_o         one-hot, one-cycle pulse carrying the result
//   resp_error_o         qualifies resp_valid_o; 1 = watchdog abort
//   resp_data_o          BCD digits, digit 0 (ones) in the LSBs
//   dd_data_in_ready_o   converter start, one-cycle pulse (during ISSUE)
//   dd_data_in_o         value to convert, stable from ISSUE until IDLE
//   dd_data_out_ready_i  converter done
//   dd_data_out_i        converter digits, flattened like resp_data_o
//   busy_o               high in every state except IDLE
// ----------------------------------------------------------------------------
module bcd_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned DATA_IN_BITS   = 12,
  parameter int unsigned DATA_OUT_BITS  = 4,
  parameter int unsigned DATA_OUT_WIDTH = 4,
  parameter int unsigned TIMEOUT_BITS   = 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NUM_REQ-1:0]                      req_valid_i,
  input  logic [NUM_REQ*DATA_IN_BITS-1:0]         req_data_i,
  output logic [NUM_REQ-1:0]                      req_ack_o,
  output logic [NUM_REQ-1:0]                      resp_valid_o,
  output logic                                    resp_error_o,
  output logic [DATA_OUT_BITS*DATA_OUT_WIDTH-1:0] resp_data_o,
  output logic                                    dd_data_in_ready_o,
  output logic [DATA_IN_BITS-1:0]                 dd_data_in_o,
  input  logic                                    dd_data_out_ready_i,
  input  logic [DATA_OUT_BITS*DATA_OUT_WIDTH-1:0] dd_data_out_i,
  output logic                                    busy_o
);

  localparam int unsigned OUT_W = DATA_OUT_BITS * DATA_OUT_WIDTH;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  localparam logic [TIMEOUT_BITS-1:0] WD_MAX    = '1;
  localparam logic [IDX_W-1:0]        LAST_INIT = IDX_W'(NUM_REQ - 1);

  // State and datapath registers
  logic [1:0]              state_q,  state_d;
  logic [IDX_W-1:0]        owner_q,  owner_d;
  logic [IDX_W-1:0]        last_q,   last_d;
  logic [TIMEOUT_BITS-1:0] wd_q,     wd_d;
  logic                    err_q,    err_d;

  // Registered outputs
  logic [NUM_REQ-1:0]      req_ack_q,    req_ack_d;
  logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
  logic                    resp_error_q, resp_error_d;
  logic [OUT_W-1:0]        resp_data_q,  resp_data_d;
  logic                    dd_ready_q,   dd_ready_d;
  logic [DATA_IN_BITS-1:0] dd_in_q,      dd_in_d;
  logic                    busy_q,       busy_d;

  // Round-robin search results
  logic                    grant_found;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        cand;
  logic [DATA_IN_BITS-1:0] grant_data;

  // Round robin: scan from last_q+1 upward with wrap, first active request wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Select the winner's data slice
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_data = req_data_i[i*DATA_IN_BITS +: DATA_IN_BITS];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    wd_d         = wd_q;
    err_d        = err_q;
    req_ack_d    = '0;
    resp_valid_d = '0;
    resp_error_d = 1'b0;
    resp_data_d  = resp_data_q;
    dd_ready_d   = 1'b0;
    dd_in_d      = dd_in_q;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          owner_d    = grant_idx;
          dd_in_d    = grant_data;
          req_ack_d  = NUM_REQ'(1) << grant_idx;
          // Start pulse is registered here so it is visible for the ISSUE cycle
          dd_ready_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // Converter done is deliberately not sampled here (stale done guard)
        wd_d    = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Done has priority over watchdog expiry in the same cycle
        if (dd_data_out_ready_i) begin
          resp_data_d = dd_data_out_i;
          err_d       = 1'b0;
          state_d     = S_RESPOND;
        end else if (wd_q == WD_MAX) begin
          resp_data_d = '0;
          err_d       = 1'b1;
          state_d     = S_RESPOND;
        end else begin
          wd_d = wd_q + TIMEOUT_BITS'(1);
        end
      end

      S_RESPOND: begin
        resp_valid_d = NUM_REQ'(1) << owner_q;
        resp_error_d = err_q;
        last_d       = owner_q;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_q       <= LAST_INIT;
      wd_q         <= '0;
      err_q        <= 1'b0;
      req_ack_q    <= '0;
      resp_valid_q <= '0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
      dd_ready_q   <= 1'b0;
      dd_in_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      req_ack_q    <= req_ack_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_data_q  <= resp_data_d;
      dd_ready_q   <= dd_ready_d;
      dd_in_q      <= dd_in_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ack_o          = req_ack_q;
  assign resp_valid_o       = resp_valid_q;
  assign resp_error_o       = resp_error_q;
  assign resp_data_o        = resp_data_q;
  assign dd_data_in_ready_o = dd_ready_q;
  assign dd_data_in_o       = dd_in_q;
  assign busy_o             = busy_q;

endmodule
